// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master / one-slave Wishbone B4 classic arbiter.
// Simultaneous requests are resolved round-robin. The owner keeps the bus
// for as long as its cyc stays high, which makes locked sequences possible.
// A watchdog returns a single-cycle err to the owner when a strobe goes
// un-acked for TIMEOUT_CYCLES cycles.
// Only the arbitration state is registered. The request and response paths
// are combinational muxes, so the arbiter adds no latency once the bus is granted.
module wb_arbiter2 #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // master 0
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  // master 1
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  // slave side
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  // one-hot owner {m1, m0}, 00 when idle
  output logic [1:0]  gnt_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // A zero timeout disables the watchdog entirely; the counter then simply
  // wraps and never produces an err.
  localparam logic [TO_WIDTH-1:0] TO_LIMIT  = TO_WIDTH'(TIMEOUT_CYCLES);
  localparam bit                  TO_ENABLE = (TIMEOUT_CYCLES != 0);

  state_t              state;
  logic                owner;   // 0 = m0, 1 = m1
  logic                last;    // previous owner, loses the next tie
  logic                err_q;   // err pulse to the owner, lasts one cycle
  logic [TO_WIDTH-1:0] to_cnt;

  logic                busy;
  logic                own_cyc;
  logic                own_stb;
  logic                any_req;
  logic                pick;
  logic                leave;
  logic                enter;
  logic                ack_ok;
  logic                to_hit;
  logic [TO_WIDTH-1:0] to_nxt;

  // Arbitration helpers: owner request lines, tie-break choice, watchdog compare
  always_comb begin
    busy    = (state == BUSY);
    own_cyc = owner ? m1_cyc_i : m0_cyc_i;
    own_stb = owner ? m1_stb_i : m0_stb_i;
    any_req = m0_cyc_i | m1_cyc_i;
    // on a tie the master that did not own the bus last wins
    pick    = (m0_cyc_i & m1_cyc_i) ? ~last : m1_cyc_i;
    enter   = ~busy & any_req;
    leave   = busy & ~own_cyc;
    to_nxt  = to_cnt + 1'b1;
    to_hit  = TO_ENABLE && (to_nxt == TO_LIMIT);
  end

  // Combinational request/response muxing from the current owner
  always_comb begin
    if (busy && owner) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
    end else begin
      // idle falls back to m0 fields; they are don't-care while cyc is low
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
    end
    s_cyc_o  = busy & own_cyc;
    // the err cycle withholds the strobe so the slave cannot start a new beat
    s_stb_o  = busy & own_stb & ~err_q;
    // an err always wins over a late ack arriving in the same cycle
    ack_ok   = busy & s_ack_i & ~err_q;
    m0_ack_o = ack_ok & ~owner;
    m1_ack_o = ack_ok & owner;
    m0_err_o = busy & err_q & ~owner;
    m1_err_o = busy & err_q & owner;
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    gnt_o    = {busy & owner, busy & ~owner};
  end

  // IDLE/BUSY arbitration FSM with owner and last-owner tracking
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= BUSY;
            owner <= pick;
            last  <= pick;
          end
        end
        BUSY: begin
          // release takes a full cycle; no re-grant until back in IDLE
          if (!own_cyc) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus-timeout watchdog counting consecutive un-acked strobe cycles
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (enter || leave || s_ack_i || err_q) begin
        to_cnt <= '0;
      end else if (s_stb_o) begin
        if (to_hit) begin
          err_q  <= 1'b1;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_nxt;
        end
      end
    end
  end

endmodule
